// File: rtl/max7219_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter that fronts the
// MAX7219 serializer.
package max7219_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        XFER,
        RELEASE
    } t_arb_state;

    localparam int C_MAX7219_FRAME_W = 16;

    // Ceiling log2 usable in parameter expressions; f_clog2(1) = 0.
    function automatic int f_clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/max7219_rr_picker.sv
// Combinational round-robin search: first set request bit at or above the
// pointer, wrapping around to bit 0.
module max7219_rr_picker
    import max7219_arb_pkg::*;
#(
    parameter int G_NB_REQ = 2,
    parameter int IDX_W    = f_clog2(G_NB_REQ)
) (
    input  logic [G_NB_REQ-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [G_NB_REQ-1:0] grant,
    output logic [IDX_W-1:0]    idx,
    output logic                valid
);

    int cand;

    // Offset i walks the requesters in priority order starting at ptr.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int i = 0; i < G_NB_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= G_NB_REQ) begin
                cand = cand - G_NB_REQ;
            end
            for (int k = 0; k < G_NB_REQ; k++) begin
                if (!valid && (cand == k) && req[k]) begin
                    grant[k] = 1'b1;
                    idx      = IDX_W'(k);
                    valid    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/max7219_if_arbiter.sv
// Shares one max7219_if serializer between several command sources; a
// requester owns the serializer for a whole burst ending on an en_load frame.
module max7219_if_arbiter
    import max7219_arb_pkg::*;
#(
    parameter int G_NB_REQ     = 2,
    parameter int G_DATA_WIDTH = C_MAX7219_FRAME_W,
    parameter int G_TIMEOUT    = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [G_NB_REQ-1:0]              i_req,
    input  logic [G_NB_REQ-1:0]              i_start,
    input  logic [G_NB_REQ-1:0]              i_en_load,
    input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_data,
    output logic [G_NB_REQ-1:0]              o_grant,
    output logic [G_NB_REQ-1:0]              o_done,
    output logic                             o_busy,
    output logic                             o_timeout,
    output logic [2:0]                       o_timeout_id,
    output logic                             o_max7219_if_start,
    output logic                             o_max7219_if_en_load,
    output logic [G_DATA_WIDTH-1:0]          o_max7219_if_data,
    input  logic                             i_max7219_if_done
);

    localparam int IDX_W = f_clog2(G_NB_REQ);
    localparam int WD_W  = f_clog2(G_TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(G_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(G_NB_REQ - 1);

    t_arb_state                state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [IDX_W-1:0]          gidx_q, gidx_d;
    logic [WD_W-1:0]           wd_q, wd_d;
    logic [G_NB_REQ-1:0]       grant_q, grant_d;
    logic [G_NB_REQ-1:0]       done_q, done_d;
    logic                      timeout_q, timeout_d;
    logic [2:0]                tid_q, tid_d;
    logic                      start_q, start_d;
    logic                      en_load_q, en_load_d;
    logic [G_DATA_WIDTH-1:0]   data_q, data_d;

    logic [G_NB_REQ-1:0]       pick_grant;
    logic [IDX_W-1:0]          pick_idx;
    logic                      pick_valid;

    logic                      sel_req;
    logic                      sel_start;
    logic                      sel_en_load;
    logic [G_DATA_WIDTH-1:0]   sel_data;

    max7219_rr_picker #(
        .G_NB_REQ (G_NB_REQ),
        .IDX_W    (IDX_W)
    ) u_picker (
        .req   (i_req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Only the granted requester's lines are ever looked at.
    always_comb begin
        sel_req     = 1'b0;
        sel_start   = 1'b0;
        sel_en_load = 1'b0;
        sel_data    = '0;
        for (int k = 0; k < G_NB_REQ; k++) begin
            if (gidx_q == IDX_W'(k)) begin
                sel_req     = i_req[k];
                sel_start   = i_start[k];
                sel_en_load = i_en_load[k];
                sel_data    = i_data[k*G_DATA_WIDTH +: G_DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        wd_d      = wd_q;
        grant_d   = grant_q;
        done_d    = '0;
        timeout_d = 1'b0;
        tid_d     = tid_q;
        start_d   = 1'b0;
        en_load_d = en_load_q;
        data_d    = data_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gidx_d  = pick_idx;
                    grant_d = pick_grant;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (sel_start) begin
                    data_d    = sel_data;
                    en_load_d = sel_en_load;
                    start_d   = 1'b1;
                    wd_d      = '0;
                    state_d   = XFER;
                end else if (!sel_req) begin
                    state_d = RELEASE;
                end
            end
            XFER: begin
                // A done arriving on the watchdog's last cycle still completes.
                wd_d = wd_q + WD_W'(1);
                if (i_max7219_if_done) begin
                    done_d  = grant_q;
                    state_d = (en_load_q || !sel_req) ? RELEASE : GRANT;
                end else if (wd_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    tid_d     = 3'(gidx_q);
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                grant_d = '0;
                ptr_d   = (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gidx_q    <= '0;
            wd_q      <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            timeout_q <= 1'b0;
            tid_q     <= '0;
            start_q   <= 1'b0;
            en_load_q <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            wd_q      <= wd_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            tid_q     <= tid_d;
            start_q   <= start_d;
            en_load_q <= en_load_d;
            data_q    <= data_d;
        end
    end

    assign o_grant              = grant_q;
    assign o_done               = done_q;
    assign o_busy               = (state_q != IDLE);
    assign o_timeout            = timeout_q;
    assign o_timeout_id         = tid_q;
    assign o_max7219_if_start   = start_q;
    assign o_max7219_if_en_load = en_load_q;
    assign o_max7219_if_data    = data_q;

endmodule

// File: tb/tb_max7219_if_arbiter.sv
// Self-checking bench for max7219_if_arbiter with an emulated serializer that
// answers each frame after a programmable delay.
module tb_max7219_if_arbiter;

    localparam int N   = 2;
    localparam int W   = 16;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    i_req;
    logic [N-1:0]    i_start;
    logic [N-1:0]    i_en_load;
    logic [N*W-1:0]  i_data;
    logic [N-1:0]    o_grant;
    logic [N-1:0]    o_done;
    logic            o_busy;
    logic            o_timeout;
    logic [2:0]      o_timeout_id;
    logic            o_max7219_if_start;
    logic            o_max7219_if_en_load;
    logic [W-1:0]    o_max7219_if_data;
    logic            i_max7219_if_done = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    int resp_delay = 2;
    bit resp_enable = 1'b1;

    int mon_starts = 0;
    int mon_loads = 0;
    int mon_timeouts = 0;
    int mon_done[N] = '{default: 0};
    logic [W-1:0] mon_data_q[$];

    max7219_if_arbiter #(
        .G_NB_REQ     (N),
        .G_DATA_WIDTH (W),
        .G_TIMEOUT    (TMO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_req                (i_req),
        .i_start              (i_start),
        .i_en_load            (i_en_load),
        .i_data               (i_data),
        .o_grant              (o_grant),
        .o_done               (o_done),
        .o_busy               (o_busy),
        .o_timeout            (o_timeout),
        .o_timeout_id         (o_timeout_id),
        .o_max7219_if_start   (o_max7219_if_start),
        .o_max7219_if_en_load (o_max7219_if_en_load),
        .o_max7219_if_data    (o_max7219_if_data),
        .i_max7219_if_done    (i_max7219_if_done)
    );

    always #5 clk = ~clk;

    // Records what reaches the serializer side and every pulse the arbiter emits.
    always @(negedge clk) begin
        if (o_max7219_if_start === 1'b1) begin
            mon_starts++;
            mon_data_q.push_back(o_max7219_if_data);
            if (o_max7219_if_en_load === 1'b1) mon_loads++;
        end
        if (o_timeout === 1'b1) mon_timeouts++;
        for (int k = 0; k < N; k++) begin
            if (o_done[k] === 1'b1) mon_done[k]++;
        end
    end

    // Serializer stand-in: done is sampled resp_delay+1 clocks after the start.
    always begin
        @(negedge clk);
        if (o_max7219_if_start === 1'b1 && resp_enable) begin
            repeat (resp_delay) @(negedge clk);
            i_max7219_if_done = 1'b1;
            @(negedge clk);
            i_max7219_if_done = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: got still running, expected finished");
        $fatal(1, "[TB] simulation hung");
    end

    function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
        for (int i = 0; i < N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_req = '0;
        i_start = '0;
        i_en_load = '0;
        resp_enable = 1'b1;
        resp_delay = 2;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (o_grant == '0 && cycles < 50);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (o_grant != '0 && cycles < 50) begin
            step();
            cycles++;
        end
    endtask

    task automatic send_frame(input int r, input logic [W-1:0] d, input bit load,
                              input bit drop, output bit start_ok, output int lat);
        i_start[r] = 1'b1;
        i_data[r*W +: W] = d;
        i_en_load[r] = load;
        if (drop) i_req[r] = 1'b0;
        step();
        start_ok = o_max7219_if_start;
        i_start[r] = 1'b0;
        lat = 0;
        while (o_done[r] !== 1'b1 && lat < 300) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        int s0;
        rst = 1'b1;
        i_req = 2'b11;
        i_start = '0;
        i_en_load = '0;
        i_data = '0;
        repeat (5) step();
        n_cmp++;
        if (o_grant !== 2'b00 || o_done !== 2'b00 || o_timeout !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_pulses: got grant=%b done=%b tmo=%b, expected 00 00 0", o_grant, o_done, o_timeout);
        end
        n_cmp++;
        if (o_busy !== 1'b0 || o_max7219_if_start !== 1'b0 || o_timeout_id !== 3'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_status: got busy=%b start=%b tid=%0d, expected 0 0 0", o_busy, o_max7219_if_start, o_timeout_id);
        end
        n_cmp++;
        if (o_max7219_if_data !== 16'h0 || o_max7219_if_en_load !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_frame: got data=%h load=%b, expected 0000 0", o_max7219_if_data, o_max7219_if_en_load);
        end
        s0 = mon_starts;
        rst = 1'b0;
        step();
        n_cmp++;
        if (o_grant !== 2'b01 || o_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_first_grant: got grant=%b busy=%b, expected 01 1", o_grant, o_busy);
        end
        i_req = '0;
        repeat (3) step();
        n_cmp++;
        if (o_grant !== 2'b00 || o_busy !== 1'b0 || mon_starts != s0) begin
            n_fail++;
            $display("[TB] FAIL grant_abandoned: got grant=%b busy=%b starts=%0d, expected 00 0 %0d", o_grant, o_busy, mon_starts, s0);
        end
    endtask

    task automatic test_single_burst();
        int s0, l0, d0, d1, q0, cyc, lat;
        bit ok;
        logic [W-1:0] exp_data;
        do_reset();
        s0 = mon_starts; l0 = mon_loads; d0 = mon_done[0]; d1 = mon_done[1];
        q0 = mon_data_q.size();
        i_req[0] = 1'b1;
        wait_grant(cyc);
        n_cmp++;
        if (o_grant !== 2'b01 || cyc != 1) begin
            n_fail++;
            $display("[TB] FAIL burst_grant: got grant=%b after %0d, expected 01 after 1", o_grant, cyc);
        end
        for (int k = 1; k <= 8; k++) begin
            resp_delay = $urandom_range(0, 5);
            exp_data = W'((k << 8) | 1);
            send_frame(0, exp_data, (k == 8), 1'b0, ok, lat);
            n_cmp++;
            if (!ok || lat >= 300 || o_busy !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL burst_frame%0d: got start=%b lat=%0d busy=%b, expected 1 <300 1", k, ok, lat, o_busy);
            end
        end
        i_req[0] = 1'b0;
        step();
        n_cmp++;
        if (o_grant !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL burst_grant_drop: got %b, expected 00", o_grant);
        end
        repeat (2) step();
        n_cmp++;
        if (mon_starts - s0 != 8 || mon_done[0] - d0 != 8 || mon_loads - l0 != 1 || mon_done[1] != d1) begin
            n_fail++;
            $display("[TB] FAIL burst_counts: got starts=%0d done0=%0d loads=%0d done1=%0d, expected 8 8 1 0",
                     mon_starts - s0, mon_done[0] - d0, mon_loads - l0, mon_done[1] - d1);
        end
        for (int k = 1; k <= 8; k++) begin
            exp_data = W'((k << 8) | 1);
            n_cmp++;
            if (mon_data_q.size() < q0 + k || mon_data_q[q0 + k - 1] !== exp_data) begin
                n_fail++;
                $display("[TB] FAIL burst_data%0d: got %h, expected %h", k,
                         (mon_data_q.size() >= q0 + k) ? mon_data_q[q0 + k - 1] : 16'hxxxx, exp_data);
            end
        end
    endtask

    task automatic test_round_robin();
        int ptr, win, cyc, idle, lat;
        bit ok;
        do_reset();
        ptr = 0;
        i_req = 2'b11;
        for (int b = 0; b < 4; b++) begin
            wait_grant(cyc);
            win = model_pick(2'b11, ptr);
            n_cmp++;
            if (o_grant !== N'(1 << win) || (b > 0 && cyc != 1)) begin
                n_fail++;
                $display("[TB] FAIL rr_burst%0d: got grant=%b wait=%0d, expected %b wait 1", b, o_grant, cyc, N'(1 << win));
            end
            resp_delay = $urandom_range(0, 4);
            send_frame(win, W'($urandom), 1'b1, 1'b0, ok, lat);
            wait_idle(idle);
            n_cmp++;
            if (!ok || lat >= 300 || idle != 1) begin
                n_fail++;
                $display("[TB] FAIL rr_release%0d: got start=%b lat=%0d idle=%0d, expected 1 <300 1", b, ok, lat, idle);
            end
            ptr = (win + 1) % N;
        end
        i_req = '0;
        repeat (3) step();
    endtask

    task automatic test_random();
        int ptr, win, cyc, idle, lat, nfr, q0;
        bit ok;
        logic [N-1:0] mask;
        logic [W-1:0] d;
        logic [W-1:0] exp_q[$];
        do_reset();
        ptr = 0;
        q0 = mon_data_q.size();
        for (int r = 0; r < 8; r++) begin
            mask = N'($urandom_range(1, 3));
            i_req = mask;
            wait_grant(cyc);
            win = model_pick(mask, ptr);
            n_cmp++;
            if (o_grant !== N'(1 << win)) begin
                n_fail++;
                $display("[TB] FAIL rand_grant%0d: got %b, expected %b (mask %b)", r, o_grant, N'(1 << win), mask);
            end
            nfr = $urandom_range(1, 3);
            for (int f = 0; f < nfr; f++) begin
                d = W'($urandom);
                exp_q.push_back(d);
                resp_delay = $urandom_range(0, 6);
                send_frame(win, d, (f == nfr - 1), 1'b0, ok, lat);
            end
            wait_idle(idle);
            ptr = (win + 1) % N;
        end
        i_req = '0;
        repeat (3) step();
        n_cmp++;
        if (mon_data_q.size() - q0 != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL rand_frame_count: got %0d, expected %0d", mon_data_q.size() - q0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && q0 + i < mon_data_q.size(); i++) begin
            n_cmp++;
            if (mon_data_q[q0 + i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL rand_frame%0d: got %h, expected %h", i, mon_data_q[q0 + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_nongranted_start();
        int s0, d0, d1, t;
        do_reset();
        s0 = mon_starts; d0 = mon_done[0]; d1 = mon_done[1];
        resp_delay = 12;
        i_req = 2'b01;
        wait_grant(t);
        i_start[0] = 1'b1; i_data[0 +: W] = 16'h1234; i_en_load[0] = 1'b1;
        step();
        i_start[0] = 1'b0;
        repeat (2) step();
        i_start = 2'b11;
        i_data = {16'hDEAD, 16'hBEEF};
        i_en_load = 2'b10;
        step();
        i_start = '0;
        t = 0;
        while (o_done[0] !== 1'b1 && t < 100) begin
            step();
            t++;
        end
        n_cmp++;
        if (o_max7219_if_data !== 16'h1234 || o_max7219_if_en_load !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ng_data_hold: got %h load=%b, expected 1234 1", o_max7219_if_data, o_max7219_if_en_load);
        end
        i_req = '0;
        repeat (4) step();
        n_cmp++;
        if (mon_starts - s0 != 1 || mon_done[1] != d1 || mon_done[0] - d0 != 1) begin
            n_fail++;
            $display("[TB] FAIL ng_counts: got starts=%0d done0=%0d done1=%0d, expected 1 1 0",
                     mon_starts - s0, mon_done[0] - d0, mon_done[1] - d1);
        end
    endtask

    task automatic test_timeout();
        int d0, d1, tm0, t, cyc;
        do_reset();
        resp_enable = 1'b0;
        d0 = mon_done[0]; d1 = mon_done[1]; tm0 = mon_timeouts;
        i_req = 2'b11;
        wait_grant(cyc);
        for (int r = 0; r < 2; r++) begin
            n_cmp++;
            if (o_grant !== N'(1 << r)) begin
                n_fail++;
                $display("[TB] FAIL tmo_grant%0d: got %b, expected %b", r, o_grant, N'(1 << r));
            end
            i_start[r] = 1'b1; i_data[r*W +: W] = 16'h0A0B; i_en_load[r] = 1'b1;
            step();
            i_start[r] = 1'b0;
            t = 0;
            while (o_timeout !== 1'b1 && t < 200) begin
                step();
                t++;
            end
            n_cmp++;
            if (t != TMO || o_timeout_id !== 3'(r)) begin
                n_fail++;
                $display("[TB] FAIL tmo_latency%0d: got %0d id=%0d, expected %0d id=%0d", r, t, o_timeout_id, TMO, r);
            end
            if (r == 1) i_req = '0;
            step();
            n_cmp++;
            if (o_timeout !== 1'b0 || o_grant !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL tmo_release%0d: got tmo=%b grant=%b, expected 0 00", r, o_timeout, o_grant);
            end
            if (r == 0) wait_grant(cyc);
        end
        repeat (3) step();
        n_cmp++;
        if (mon_done[0] != d0 || mon_done[1] != d1 || mon_timeouts - tm0 != 2 || o_timeout_id !== 3'd1) begin
            n_fail++;
            $display("[TB] FAIL tmo_counts: got done=%0d/%0d tmo=%0d id=%0d, expected 0/0 2 1",
                     mon_done[0] - d0, mon_done[1] - d1, mon_timeouts - tm0, o_timeout_id);
        end
        resp_enable = 1'b1;
    endtask

    task automatic test_edges();
        int s0, d0, tm0, t, lat, idle;
        bit ok;
        // done on the watchdog's last cycle
        do_reset();
        tm0 = mon_timeouts;
        resp_delay = TMO - 1;
        i_req = 2'b01;
        wait_grant(t);
        send_frame(0, 16'h5555, 1'b1, 1'b0, ok, lat);
        i_req = '0;
        repeat (3) step();
        n_cmp++;
        if (lat != TMO || mon_timeouts != tm0) begin
            n_fail++;
            $display("[TB] FAIL edge_done_wins: got lat=%0d tmo=%0d, expected %0d 0", lat, mon_timeouts - tm0, TMO);
        end
        // done one cycle too late
        d0 = mon_done[0];
        resp_delay = TMO;
        i_req = 2'b01;
        wait_grant(t);
        send_frame(0, 16'h6666, 1'b1, 1'b0, ok, lat);
        i_req = '0;
        repeat (10) step();
        n_cmp++;
        if (mon_done[0] != d0 || mon_timeouts - tm0 != 1 || o_grant !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL edge_late_done: got done=%0d tmo=%0d grant=%b, expected 0 1 00",
                     mon_done[0] - d0, mon_timeouts - tm0, o_grant);
        end
        // start wins over a same-cycle request drop
        s0 = mon_starts;
        resp_delay = 2;
        i_req = 2'b01;
        wait_grant(t);
        send_frame(0, 16'h7777, 1'b0, 1'b1, ok, lat);
        wait_idle(idle);
        n_cmp++;
        if (!ok || lat >= 300 || idle != 1 || mon_starts - s0 != 1 || o_max7219_if_en_load !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL edge_start_wins: got start=%b lat=%0d idle=%0d starts=%0d load=%b, expected 1 <300 1 1 0",
                     ok, lat, idle, mon_starts - s0, o_max7219_if_en_load);
        end
        // reset in the middle of a transfer
        repeat (3) step();
        d0 = mon_done[0];
        resp_delay = 20;
        i_req = 2'b01;
        wait_grant(t);
        i_start[0] = 1'b1; i_data[0 +: W] = 16'h9999; i_en_load[0] = 1'b1;
        step();
        i_start[0] = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        i_req = '0;
        n_cmp++;
        if (o_grant !== 2'b00 || o_busy !== 1'b0 || o_max7219_if_data !== 16'h0 || o_max7219_if_en_load !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL edge_reset_xfer: got grant=%b busy=%b data=%h load=%b, expected 00 0 0000 0",
                     o_grant, o_busy, o_max7219_if_data, o_max7219_if_en_load);
        end
        repeat (30) step();
        n_cmp++;
        if (mon_done[0] != d0) begin
            n_fail++;
            $display("[TB] FAIL edge_reset_no_done: got %0d done pulses, expected 0", mon_done[0] - d0);
        end
    endtask

    initial begin
        $display("[TB] starting max7219_if_arbiter bench");
        test_reset();
        test_single_burst();
        test_round_robin();
        test_random();
        test_nongranted_start();
        test_timeout();
        test_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/max7219_if_arbiter.md
Name: max7219_if_arbiter

Overview:
Round-robin arbiter that shares one max7219_if serializer between G_NB_REQ command sources, such as the static command decoder and a scroll engine. A requester holds the grant for a whole burst of 16-bit frames, and the burst ends with the frame flagged en_load. The arbiter forwards each start/done handshake, registers the frame data so it stays stable, and releases a hung transfer through a watchdog.

Parameters:
G_NB_REQ, 2, number of requesters (2..8)
G_DATA_WIDTH, 16, frame width (MAX7219 address+data word)
G_TIMEOUT, 1024, cycles allowed from o_max7219_if_start to i_max7219_if_done before abort (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
i_req  in  G_NB_REQ  per-requester bus request; level, held for the whole burst
i_start  in  G_NB_REQ  per-requester frame start pulse; valid only while granted
i_en_load  in  G_NB_REQ  per-requester flag: this frame is the last of the burst (LOAD)
i_data  in  G_NB_REQ*G_DATA_WIDTH  per-requester frame; slice k = [k*W +: W]
o_grant  out  G_NB_REQ  one-hot grant, registered
o_done  out  G_NB_REQ  per-requester frame-done pulse, 1 cycle
o_busy  out  1  high whenever state != IDLE
o_timeout  out  1  1-cycle pulse on watchdog abort
o_timeout_id  out  3  index of the requester aborted; holds until next timeout
o_max7219_if_start  out  1  1-cycle start to max7219_if
o_max7219_if_en_load  out  1  registered en_load to max7219_if
o_max7219_if_data  out  G_DATA_WIDTH  registered frame to max7219_if
i_max7219_if_done  in  1  max7219_if frame-complete pulse

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; every output is 0; the round-robin pointer is 0; the watchdog is 0. Reset mid-transfer abandons the transfer and emits no o_done.
- State IDLE:
  - If i_req != 0, pick the first set bit scanning from the pointer upward with wrap.
  - o_grant[g] goes high on the next cycle and the state moves to GRANT. Latency req->grant = 1 cycle.
- State GRANT:
  - If i_start[g]=1, latch i_data slice g and i_en_load[g] into o_max7219_if_data / o_max7219_if_en_load.
  - Pulse o_max7219_if_start on the next cycle, clear the watchdog, and go to XFER. Latency start->if_start = 1 cycle.
  - Otherwise, if i_req[g]=0, go to RELEASE.
  - If i_start[g] and i_req[g] fall in the same cycle, the start wins.
- State XFER:
  - The watchdog increments every cycle. Data and en_load outputs stay constant.
  - On i_max7219_if_done: pulse o_done[g] on the next cycle. Next state is RELEASE if the latched en_load=1 or i_req[g]=0, else GRANT.
  - If the watchdog reaches G_TIMEOUT-1 with no done: pulse o_timeout, set o_timeout_id=g, go to RELEASE, no o_done.
  - If done and timeout fall in the same cycle, done wins.
- State RELEASE: o_grant=0; pointer = (g+1) mod G_NB_REQ; go to IDLE. There is always at least one idle cycle between bursts.
- Ignored inputs:
  - i_start from a non-granted requester: no effect, no o_done.
  - i_start while in XFER: no effect.
  - i_max7219_if_done outside XFER: no effect.
- o_max7219_if_en_load and o_max7219_if_data keep their last value after a transfer and are not cleared.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,N-1,0. No requester waits more than N-1 bursts.

Decomposition:
- Package max7219_arb_pkg:
  - state enum t_arb_state {IDLE, GRANT, XFER, RELEASE}
  - C_MAX7219_FRAME_W = 16
  - function f_clog2
- Watchdog counter width is f_clog2(G_TIMEOUT).
- One sub-module, max7219_rr_picker: combinational round-robin first-set search. Inputs: request vector and pointer. Outputs: one-hot grant and index. Kept separate so it can be unit-tested.

Test Plan:
- Reset: rst=1 for 5 cycles with i_req=2'b11 -> all outputs 0, o_busy=0. After release, o_grant=2'b01 one cycle later (pointer 0).
- Single burst: req0 sends 8 frames 0x0101..0x0801, en_load=1 on the 8th, with max7219_if G_MAX_HALF_PERIOD=4 attached:
  - exactly 8 o_max7219_if_start pulses, each data matching the frame;
  - 8 o_done[0] pulses;
  - grant drops after the 8th done; SPI checker receives 8 frames and 1 load.
- Round-robin: i_req=2'b11 held, each requester sends 1 frame with en_load=1 per burst, 4 bursts -> grant order 0,1,0,1 with a 1-cycle idle gap between bursts.
- Non-granted start: req1 pulses i_start with data 0xDEAD while req0 is mid-XFER -> no extra if_start, no o_done[1]; if_data stays at req0's frame.
- Timeout: G_TIMEOUT=64, i_max7219_if_done tied 0 -> o_timeout pulses exactly 64 cycles after if_start with o_timeout_id=0; grant released; the next burst is granted to req1.
- Edge cases:
  - done and timeout on the same cycle -> o_done pulses and o_timeout stays 0;
  - rst asserted mid-XFER -> no o_done, outputs 0 next cycle.
